// File: rtl/serial_adder_n.sv
// Bit-serial adder/subtractor: one full-adder slice reused over WIDTH cycles,
// LSB first, with a start/busy/done handshake and signed-overflow flag.
module serial_adder_n #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    // a_q doubles as the result shift register: each consumed operand bit
    // frees its MSB slot for a result bit, so after WIDTH shifts it holds
    // the finished sum.
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;
    logic             bit_s, carry_nx, last;

    always_comb begin
        bit_s    = a_q[0] ^ b_q[0] ^ carry_q;
        carry_nx = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
        last     = (cnt_q == CNT_W'(WIDTH - 1));

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    state_d = S_RUN;
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = c_in ^ sub;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                a_d     = {bit_s, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                carry_d = carry_nx;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last) begin
                    state_d = S_DONE;
                    sum_d   = {bit_s, a_q[WIDTH-1:1]};
                    c_out_d = carry_nx;
                    // carry_q here is the carry into the MSB slice
                    ovf_d   = carry_q ^ carry_nx;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy  = (state_q == S_RUN);
    assign done  = (state_q == S_DONE);
    assign sum   = sum_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;
endmodule

// File: tb/tb_serial_adder_n.sv
// Directed bench for serial_adder_n at WIDTH 8, plus exhaustive WIDTH 2 and
// random WIDTH 16 runs against an arithmetic model.
module tb_serial_adder_n;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic       s8 = 0, c8 = 0, u8 = 0;
    logic [7:0] a8 = 0, b8 = 0;
    logic       busy8, done8, co8, ov8;
    logic [7:0] sum8;

    logic       s2 = 0, c2 = 0, u2 = 0;
    logic [1:0] a2 = 0, b2 = 0;
    logic       busy2, done2, co2, ov2;
    logic [1:0] sum2;

    logic        s16 = 0, c16 = 0, u16 = 0;
    logic [15:0] a16 = 0, b16 = 0;
    logic        busy16, done16, co16, ov16;
    logic [15:0] sum16;

    serial_adder_n #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8),
        .c_in(c8), .sub(u8), .busy(busy8), .done(done8), .sum(sum8), .c_out(co8), .ovf(ov8));
    serial_adder_n #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .start(s2), .a(a2), .b(b2),
        .c_in(c2), .sub(u2), .busy(busy2), .done(done2), .sum(sum2), .c_out(co2), .ovf(ov2));
    serial_adder_n #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .start(s16), .a(a16), .b(b16),
        .c_in(c16), .sub(u16), .busy(busy16), .done(done16), .sum(sum16), .c_out(co16), .ovf(ov16));

    // returns {ovf, c_out, sum} for a raw WIDTH-bit adder fed a, b^sub, c_in^sub
    function automatic logic [17:0] model(input int w, input longint unsigned a, input longint unsigned b,
                                          input logic c, input logic s);
        longint unsigned mask, bp, full, sm;
        logic co, ov, sa, sb, ss;
        mask = (64'd1 << w) - 1;
        bp   = s ? (~b & mask) : (b & mask);
        full = a + bp + ((c ^ s) ? 1 : 0);
        sm   = full & mask;
        co   = full[w];
        sa   = a[w-1];
        sb   = bp[w-1];
        ss   = sm[w-1];
        ov   = (sa == sb) && (ss != sa);
        return {ov, co, sm[15:0]};
    endfunction

    // drive one WIDTH-8 op; lat = edges from accepting edge until done seen
    task automatic do_op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input logic ts,
                          output int lat);
        @(posedge clk); #1;
        a8 = ta; b8 = tb; c8 = tc; u8 = ts; s8 = 1'b1;
        @(posedge clk); #1;
        s8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        #12;
        n_chk++;
        if ({busy8, done8, sum8, co8, ov8} !== 12'h0 || {busy2, done2, sum2, co2, ov2} !== 6'h0 ||
            {busy16, done16, sum16, co16, ov16} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_state: got w8=%h w2=%h w16=%h, expected all zero",
                     {busy8, done8, sum8, co8, ov8}, {busy2, done2, sum2, co2, ov2},
                     {busy16, done16, sum16, co16, ov16});
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_add();
        int lat;
        do_op8(8'h5A, 8'h33, 1'b0, 1'b0, lat);
        n_chk++;
        if (lat !== 8) begin n_fail++; $display("FAIL add_latency: got %0d expected 8", lat); end
        n_chk++;
        if ({ov8, co8, sum8} !== {1'b1, 1'b0, 8'h8D}) begin
            n_fail++; $display("FAIL add_5a_33: got ovf=%b c=%b sum=%h expected 1 0 8d", ov8, co8, sum8);
        end
        @(posedge clk); #1;
        n_chk++;
        if (done8 !== 1'b0 || busy8 !== 1'b0) begin
            n_fail++; $display("FAIL done_single_cycle: got done=%b busy=%b expected 0 0", done8, busy8);
        end
        do_op8(8'hFF, 8'h01, 1'b0, 1'b0, lat);
        n_chk++;
        if ({ov8, co8, sum8} !== {1'b0, 1'b1, 8'h00}) begin
            n_fail++; $display("FAIL add_ff_01: got ovf=%b c=%b sum=%h expected 0 1 00", ov8, co8, sum8);
        end
        do_op8(8'h7F, 8'h00, 1'b1, 1'b0, lat);
        n_chk++;
        if ({ov8, co8, sum8} !== {1'b1, 1'b0, 8'h80}) begin
            n_fail++; $display("FAIL add_7f_cin: got ovf=%b c=%b sum=%h expected 1 0 80", ov8, co8, sum8);
        end
    endtask

    task automatic test_sub();
        int lat;
        do_op8(8'h10, 8'h20, 1'b0, 1'b1, lat);
        n_chk++;
        if ({ov8, co8, sum8} !== {1'b0, 1'b0, 8'hF0}) begin
            n_fail++; $display("FAIL sub_10_20: got ovf=%b c=%b sum=%h expected 0 0 f0", ov8, co8, sum8);
        end
        do_op8(8'h80, 8'h01, 1'b0, 1'b1, lat);
        n_chk++;
        if ({ov8, co8, sum8} !== {1'b1, 1'b1, 8'h7F}) begin
            n_fail++; $display("FAIL sub_80_01: got ovf=%b c=%b sum=%h expected 1 1 7f", ov8, co8, sum8);
        end
        do_op8(8'h05, 8'h05, 1'b1, 1'b1, lat);
        n_chk++;
        if ({ov8, co8, sum8} !== {1'b0, 1'b0, 8'hFF}) begin
            n_fail++; $display("FAIL sub_05_05_bin: got ovf=%b c=%b sum=%h expected 0 0 ff", ov8, co8, sum8);
        end
    endtask

    task automatic test_start_in_run();
        int lat;
        @(posedge clk); #1;
        a8 = 8'h12; b8 = 8'h34; c8 = 1'b0; u8 = 1'b0; s8 = 1'b1;
        @(posedge clk); #1;
        s8 = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1; u8 = 1'b1; s8 = 1'b1;
        @(posedge clk); #1;
        s8 = 1'b0;
        lat = 4;
        while (!done8 && lat < 40) begin @(posedge clk); #1; lat++; end
        n_chk++;
        if (lat !== 8 || sum8 !== 8'h46 || co8 !== 1'b0) begin
            n_fail++; $display("FAIL start_in_run: got lat=%0d sum=%h c=%b expected 8 46 0", lat, sum8, co8);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(posedge clk); #1;
        a8 = 8'h01; b8 = 8'h02; c8 = 1'b0; u8 = 1'b0; s8 = 1'b1;
        @(posedge clk); #1;
        a8 = 8'h10; b8 = 8'h20;
        lat = 0;
        while (!done8 && lat < 40) begin @(posedge clk); #1; lat++; end
        n_chk++;
        if (lat !== 8 || sum8 !== 8'h03 || busy8 !== 1'b0) begin
            n_fail++; $display("FAIL b2b_first: got lat=%0d sum=%h busy=%b expected 8 03 0", lat, sum8, busy8);
        end
        @(posedge clk); #1;
        s8 = 1'b0;
        n_chk++;
        if (busy8 !== 1'b1 || done8 !== 1'b0 || sum8 !== 8'h03) begin
            n_fail++; $display("FAIL b2b_restart: got busy=%b done=%b sum=%h expected 1 0 03", busy8, done8, sum8);
        end
        lat = 0;
        while (!done8 && lat < 40) begin @(posedge clk); #1; lat++; end
        n_chk++;
        if (lat !== 8 || sum8 !== 8'h30) begin
            n_fail++; $display("FAIL b2b_second: got lat=%0d sum=%h expected 8 30", lat, sum8);
        end
    endtask

    task automatic test_async_reset();
        int lat;
        logic seen;
        @(posedge clk); #1;
        a8 = 8'hAA; b8 = 8'h11; c8 = 1'b0; u8 = 1'b0; s8 = 1'b1;
        @(posedge clk); #1;
        s8 = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({busy8, done8, sum8, co8, ov8} !== 12'h0) begin
            n_fail++; $display("FAIL async_reset: got %h expected 000", {busy8, done8, sum8, co8, ov8});
        end
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin @(posedge clk); #1; if (done8) seen = 1'b1; end
        n_chk++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL reset_no_done: got done=1 expected none"); end
        do_op8(8'h22, 8'h11, 1'b0, 1'b0, lat);
        n_chk++;
        if (lat !== 8 || sum8 !== 8'h33) begin
            n_fail++; $display("FAIL after_reset: got lat=%0d sum=%h expected 8 33", lat, sum8);
        end
    endtask

    task automatic test_w2_exhaustive();
        int lat, bad;
        logic [17:0] exp;
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk); #1;
            a2 = i[1:0]; b2 = i[3:2]; c2 = i[4]; u2 = i[5]; s2 = 1'b1;
            @(posedge clk); #1;
            s2 = 1'b0;
            lat = 0;
            while (!done2 && lat < 20) begin @(posedge clk); #1; lat++; end
            exp = model(2, i[1:0], i[3:2], i[4], i[5]);
            n_chk++;
            if (lat !== 2 || {ov2, co2, sum2} !== {exp[17:16], exp[1:0]}) begin
                n_fail++; bad++;
                if (bad < 5)
                    $display("FAIL w2_case%0d: got lat=%0d ovf/c/sum=%b expected lat=2 %b",
                             i, lat, {ov2, co2, sum2}, {exp[17:16], exp[1:0]});
            end
        end
    endtask

    task automatic test_w16_random();
        int lat, bad;
        logic [17:0] exp;
        logic [17:0] prev;
        logic unstable;
        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            prev = {ov16, co16, sum16};
            unstable = 1'b0;
            @(posedge clk); #1;
            a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom); u16 = 1'($urandom); s16 = 1'b1;
            exp = model(16, a16, b16, c16, u16);
            @(posedge clk); #1;
            s16 = 1'b0;
            lat = 0;
            while (!done16 && lat < 40) begin
                if ({ov16, co16, sum16} !== prev) unstable = 1'b1;
                @(posedge clk); #1; lat++;
            end
            n_chk++;
            if (lat !== 16 || {ov16, co16, sum16} !== exp || unstable) begin
                n_fail++; bad++;
                if (bad < 5)
                    $display("FAIL w16_op%0d: got lat=%0d res=%h unstable=%b expected 16 %h 0",
                             i, lat, {ov16, co16, sum16}, unstable, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_start_in_run();
        test_back_to_back();
        test_async_reset();
        test_w2_exhaustive();
        test_w16_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
